// File: rtl/wing_port_dir_sequencer_if.sv
// User-side signal bundle for one DE0 IO wing port sequencer.
// The transceiver pins (BUS, IO, OE) stay on the sequencer itself.
interface wing_port_dir_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             dir_req;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             busy;
  logic             dir_cur;

  // User logic side: requests a direction, supplies outbound data.
  modport master (
    output dir_req, dout,
    input  din, din_valid, busy, dir_cur
  );

  // Sequencer side.
  modport slave (
    input  dir_req, dout,
    output din, din_valid, busy, dir_cur
  );
endinterface

// File: rtl/wing_port_dir_sequencer.sv
// Direction sequencer for one 8-bit port of the DE0 digital IO wing
// (SN74LVC8T245). A direction request becomes: disable OE, settle,
// flip DIR, settle, re-enable OE. Inbound data is synchronised and
// qualified; outbound data is registered before reaching the pins.
module wing_port_dir_sequencer #(
  parameter int WIDTH       = 8,
  parameter int OE_SETTLE   = 4,
  parameter int DIR_SETTLE  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  wing_port_dir_sequencer_if.slave    usr,
  inout  wire  [WIDTH-1:0]            BUS,
  output logic                        IO,
  output logic                        OE
);

  localparam int MAX_SETTLE = (OE_SETTLE > DIR_SETTLE) ? OE_SETTLE : DIR_SETTLE;
  localparam int CNT_W      = $clog2(MAX_SETTLE + 1);
  localparam int VC_W       = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SWITCH = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgt_q, tgt_d;
  logic             cur_q, cur_d;
  logic             io_q, io_d;
  logic [VC_W-1:0]  vcnt_q, vcnt_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic             in_mode;
  logic             drive;

  // Control state register: reset behaves like having just entered OFF toward input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      cur_q   <= 1'b0;
      io_q    <= 1'b0;
      vcnt_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      io_q    <= io_d;
      vcnt_q  <= vcnt_d;
      vld_q   <= vld_d;
    end
  end

  // Turnaround sequencing; requests arriving while busy are deliberately ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    io_d    = io_q;
    case (state_q)
      ST_OFF: begin
        if (cnt_q == CNT_W'(OE_SETTLE - 1)) begin
          state_d = ST_SWITCH;
          cnt_d   = '0;
          io_d    = tgt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SWITCH: begin
        if (cnt_q == CNT_W'(DIR_SETTLE - 1)) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          cur_d   = tgt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (usr.dir_req != cur_q) begin
          state_d = ST_OFF;
          tgt_d   = usr.dir_req;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Inbound qualification: valid once the synchroniser has been fully refilled in input mode.
  always_comb begin
    in_mode = (state_q == ST_ACTIVE) && !cur_q;
    vcnt_d  = '0;
    if (in_mode && (state_d == ST_ACTIVE)) begin
      if (vcnt_q == VC_W'(SYNC_STAGES)) begin
        vcnt_d = vcnt_q;
      end else begin
        vcnt_d = vcnt_q + VC_W'(1);
      end
    end
    vld_d = (vcnt_d == VC_W'(SYNC_STAGES));
  end

  // Inbound synchroniser chain, sampled every cycle regardless of direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= BUS;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Outbound data register; pure data path, no reset needed.
  always_ff @(posedge clk) begin
    dout_q <= usr.dout;
  end

  // Pin drive: rst forces the transceiver off and the bus released without waiting for a clock.
  assign drive = !rst && (state_q == ST_ACTIVE) && cur_q;
  assign BUS   = drive ? dout_q : {WIDTH{1'bz}};
  assign OE    = rst || (state_q != ST_ACTIVE);
  assign IO    = io_q;

  assign usr.din       = sync_q[SYNC_STAGES-1];
  assign usr.din_valid = vld_q;
  assign usr.busy      = (state_q != ST_ACTIVE);
  assign usr.dir_cur   = cur_q;

endmodule

// File: tb/tb_wing_port_dir_sequencer.sv
// Scoreboard bench for wing_port_dir_sequencer: a turnaround-timer model
// predicts the outputs after each clock edge, a monitor compares them.
module tb_wing_port_dir_sequencer;

  localparam int W    = 8;
  localparam int OES  = 4;
  localparam int DIRS = 2;
  localparam int TURN = OES + DIRS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] wing = '0;
  wire  [W-1:0] bus;
  logic         io, oe;

  wing_port_dir_sequencer_if #(.WIDTH(W)) u_if ();

  wing_port_dir_sequencer #(
    .WIDTH(W), .OE_SETTLE(OES), .DIR_SETTLE(DIRS), .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .usr(u_if.slave),
    .BUS(bus),
    .IO(io),
    .OE(oe)
  );

  // Wing side of the transceiver drives the FPGA pins only when enabled toward the FPGA.
  assign bus = (!oe && !io) ? wing : {W{1'bz}};

  always #5 clk = ~clk;

  typedef struct packed {
    logic         oe;
    logic         io;
    logic         busy;
    logic         cur;
    logic         vld;
    logic         chk_din;
    logic [W-1:0] din;
    logic         chk_bus;
    logic [W-1:0] bus;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // Model: m_left = cycles still to go in a turnaround (0 = settled).
  int           m_left;
  logic         m_cur, m_tgt, m_io;
  int           m_vcnt;
  logic [W-1:0] h0, h1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_left = TURN;
    m_cur  = 1'b0;
    m_tgt  = 1'b0;
    m_io   = 1'b0;
    m_vcnt = 0;
  endfunction

  // Predict outputs after the coming edge, given the inputs held across it.
  task automatic model_step(input logic req, input logic [W-1:0] d, input logic [W-1:0] w);
    exp_t e;
    bit   in_before, in_after;
    in_before = (m_left == 0) && !m_cur;
    h1 = h0;
    h0 = w;
    if (m_left == 0) begin
      if (req != m_cur) begin
        m_left = TURN;
        m_tgt  = req;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_cur = m_tgt;
    end
    if (m_left <= DIRS) m_io = m_tgt;
    in_after = (m_left == 0) && !m_cur;
    m_vcnt   = (in_before && in_after) ? m_vcnt + 1 : 0;
    e.oe      = (m_left != 0);
    e.busy    = (m_left != 0);
    e.io      = m_io;
    e.cur     = m_cur;
    e.vld     = (m_vcnt >= 2);
    e.chk_din = e.vld;
    e.din     = h1;
    e.chk_bus = (m_left == 0) && m_cur;
    e.bus     = d;
    expq.push_back(e);
  endtask

  // One clock of stimulus, entered and left at a falling edge.
  task automatic cyc(input logic req, input logic [W-1:0] d, input logic [W-1:0] w);
    u_if.dir_req = req;
    u_if.dout    = d;
    wing         = w;
    model_step(req, d, w);
    @(negedge clk);
  endtask

  // Assert reset at a falling edge, check the immediate effect, hold, then release.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_oe"},   int'(oe), 1);
    chk({tag, "_io"},   int'(io), 0);
    chk({tag, "_vld"},  int'(u_if.din_valid), 0);
    chk({tag, "_busy"}, int'(u_if.busy), 1);
    chk({tag, "_cur"},  int'(u_if.dir_cur), 0);
    chk({tag, "_din"},  int'(u_if.din), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compare the DUT against every queued prediction just after each edge.
  int oe_run = 0;
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("oe",        int'(oe), int'(e.oe));
      chk("io",        int'(io), int'(e.io));
      chk("busy",      int'(u_if.busy), int'(e.busy));
      chk("dir_cur",   int'(u_if.dir_cur), int'(e.cur));
      chk("din_valid", int'(u_if.din_valid), int'(e.vld));
      if (e.chk_din) chk("din", int'(u_if.din), int'(e.din));
      if (e.chk_bus) chk("bus", int'(bus), int'(e.bus));
    end
    if (oe) begin
      oe_run++;
    end else begin
      if (oe_run > 0) chk("oe_high_len_ok", int'(oe_run >= TURN), 1);
      oe_run = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic req;
    u_if.dir_req = 1'b0;
    u_if.dout    = '0;
    h0 = '0;
    h1 = '0;
    model_reset();
    @(negedge clk);
    do_reset("rst0");

    // Reset sequence into input mode, wing presenting A5.
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'h3C, 8'hA5);
    // Turn around to output.
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'h3C, 8'hA5);
    // Output mode data step 00 -> FF.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 8'h11);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF, 8'h22);
    // 1 -> 0 -> 1 while a turnaround is in flight.
    cyc(1'b0, 8'h5A, 8'h33);
    cyc(1'b0, 8'h5A, 8'h33);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h5A, 8'h44);
    // Request input, then reset two cycles into OFF.
    cyc(1'b0, 8'h12, 8'h55);
    cyc(1'b0, 8'h12, 8'h55);
    do_reset("rst_mid");
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'h77, 8'h66);

    // Random direction toggling with random data on both sides.
    req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) req = ~req;
      cyc(req, W'($urandom), W'($urandom));
    end
    for (int i = 0; i < 3; i++) cyc(req, 8'h00, 8'h00);

    @(posedge clk);
    #2;
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
